// File: rtl/cmd_mem_pkg.sv
// Shared types and constants for the command bank memory.
// CMD_MEM_DEFAULTS_EN selects whether bank 0 resets to DEF_TABLE.
package cmd_mem_pkg;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_TOO_WIDE = 3'd1,
    ERR_BAD_ADDR = 3'd2,
    ERR_NO_SPACE = 3'd3,
    ERR_FULL     = 3'd4,
    ERR_BAD_BANK = 3'd5,
    ERR_SYNTAX   = 3'd6
  } err_code_e;

  typedef enum logic [2:0] {
    P_FIRST, P_SECOND, P_SPACE, P_TEXT, P_WAIT_LF, P_DISCARD, P_COMMIT
  } pstate_e;

  typedef enum logic [1:0] {
    K_WRITE, K_BANK, K_CLEAR
  } line_kind_e;

  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_B  = 8'h42;
  localparam logic [7:0] ASC_C  = 8'h43;
  localparam logic [7:0] ASC_R  = 8'h52;

  // Default command table: "AT", "ATI"
  localparam int unsigned DEF_LEN = 2;
  localparam int unsigned DEF_W   = 4;
  localparam int unsigned DEF_LW  = 1;
  localparam int unsigned DEF_WW  = 2;
  localparam logic [7:0] DEF_TABLE [DEF_LEN][DEF_W] = '{
    '{8'h41, 8'h54, 8'h00, 8'h00},
    '{8'h41, 8'h54, 8'h49, 8'h00}
  };

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic [3:0] digit_val(input logic [7:0] b);
    return 4'(b - ASC_0);
  endfunction

  function automatic logic [7:0] def_byte(input int unsigned s, input int unsigned k);
    if ((s < DEF_LEN) && (k < DEF_W)) return DEF_TABLE[DEF_LW'(s)][DEF_WW'(k)];
    return 8'h00;
  endfunction

endpackage

// File: rtl/cmd_bank_memory_if.sv
// RX FIFO handshake between the FIFO (master) and the command memory (slave).
interface cmd_bank_memory_if;
  logic       data_ready;
  logic       data_valid;
  logic [7:0] cmd_data;
  logic       rd_en;

  modport master (output data_ready, data_valid, cmd_data, input rd_en);
  modport slave  (input data_ready, data_valid, cmd_data, output rd_en);
endinterface

// File: rtl/cmd_line_parser.sv
// Line parser: decodes "NN text", "Bn" and "CR" lines byte by byte and
// reports the decoded slot/bank/kind, staged text length and errors.
module cmd_line_parser
  import cmd_mem_pkg::*;
#(
  parameter int unsigned CMD_WIDTH = 32,
  parameter int unsigned CMD_DEPTH = 16,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned LW        = $clog2(CMD_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          byte_stb,
  input  logic [7:0]    byte_in,
  input  logic [6:0]    cnt,
  input  logic          commit_done,
  output pstate_e       state,
  output line_kind_e    kind,
  output logic [6:0]    slot,
  output logic [3:0]    bank_sel,
  output logic [LW-1:0] txt_len,
  output logic          txt_we,
  output logic          error_pulse,
  output err_code_e     error_code
);

  pstate_e       state_n;
  line_kind_e    kind_n;
  logic [6:0]    slot_n;
  logic [6:0]    nn;
  logic [3:0]    bank_n;
  logic [LW-1:0] len_n;
  err_code_e     err;

  // State, decoded fields and registered error report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= P_FIRST;
      kind        <= K_WRITE;
      slot        <= '0;
      bank_sel    <= '0;
      txt_len     <= '0;
      error_pulse <= 1'b0;
      error_code  <= ERR_NONE;
    end else begin
      state       <= state_n;
      kind        <= kind_n;
      slot        <= slot_n;
      bank_sel    <= bank_n;
      txt_len     <= len_n;
      error_pulse <= (err != ERR_NONE);
      if (err != ERR_NONE) error_code <= err;
    end
  end

  // Next-state decode; errors are flagged as soon as the offending byte arrives
  always_comb begin
    state_n = state;
    kind_n  = kind;
    slot_n  = slot;
    bank_n  = bank_sel;
    len_n   = txt_len;
    txt_we  = 1'b0;
    err     = ERR_NONE;
    nn      = slot * 7'd10 + {3'b000, digit_val(byte_in)};
    if (!enable && (state != P_COMMIT)) begin
      state_n = P_FIRST;
      len_n   = '0;
    end else if (state == P_COMMIT) begin
      if (commit_done) state_n = P_FIRST;
    end else if (byte_stb) begin
      case (state)
        P_FIRST: begin
          len_n = '0;
          if (is_digit(byte_in)) begin
            kind_n  = K_WRITE;
            slot_n  = {3'b000, digit_val(byte_in)};
            state_n = P_SECOND;
          end else if (byte_in == ASC_B) begin
            kind_n  = K_BANK;
            state_n = P_SECOND;
          end else if (byte_in == ASC_C) begin
            kind_n  = K_CLEAR;
            state_n = P_SECOND;
          end else err = ERR_SYNTAX;
        end
        P_SECOND: begin
          case (kind)
            K_WRITE: begin
              if (is_digit(byte_in)) begin
                slot_n = nn;
                if (nn > cnt) err = ERR_BAD_ADDR;
                else if ((nn == cnt) && (32'(cnt) >= CMD_DEPTH)) err = ERR_FULL;
                else state_n = P_SPACE;
              end else if ((byte_in == ASC_CR) || (byte_in == ASC_LF)) err = ERR_SYNTAX;
              else err = ERR_NO_SPACE;
            end
            K_BANK: begin
              if (!is_digit(byte_in)) err = ERR_SYNTAX;
              else if (32'(digit_val(byte_in)) >= NUM_BANKS) err = ERR_BAD_BANK;
              else begin
                bank_n  = digit_val(byte_in);
                state_n = P_SPACE;
              end
            end
            default: begin
              if (byte_in == ASC_R) state_n = P_SPACE;
              else err = ERR_SYNTAX;
            end
          endcase
        end
        P_SPACE: begin
          if (kind == K_WRITE) begin
            if (byte_in == ASC_SP) state_n = P_TEXT;
            else err = ERR_NO_SPACE;
          end else if (byte_in == ASC_CR) state_n = P_WAIT_LF;
          else err = ERR_SYNTAX;
        end
        P_TEXT: begin
          if (byte_in == ASC_CR) state_n = P_WAIT_LF;
          else if (byte_in == ASC_LF) err = ERR_SYNTAX;
          else if (32'(txt_len) == CMD_WIDTH) err = ERR_TOO_WIDE;
          else begin
            txt_we = 1'b1;
            len_n  = txt_len + 1'b1;
          end
        end
        P_WAIT_LF: begin
          if (byte_in == ASC_LF) state_n = P_COMMIT;
          else err = ERR_SYNTAX;
        end
        P_DISCARD: begin
          if (byte_in == ASC_LF) state_n = P_FIRST;
        end
        default: state_n = P_FIRST;
      endcase
      // An error on the LF itself already ends the line
      if (err != ERR_NONE) state_n = (byte_in == ASC_LF) ? P_FIRST : P_DISCARD;
    end
  end

endmodule

// File: rtl/cmd_bank_memory.sv
// Banked command memory programmed from an RX byte FIFO. Holds the
// fetcher, line buffer, banks and the line-atomic commit engine.
// Define CMD_MEM_DEFAULTS_EN to preload bank 0 from the package table.
module cmd_bank_memory
  import cmd_mem_pkg::*;
#(
  parameter int unsigned CMD_WIDTH = 32,
  parameter int unsigned CMD_DEPTH = 16,
  parameter int unsigned NUM_BANKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  cmd_bank_memory_if.slave rx,
  input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] rd_bank,
  input  logic [$clog2(CMD_DEPTH*CMD_WIDTH+1)-1:0]             rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       write_done,
  output logic       error_pulse,
  output logic [2:0] error_code
);

  localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned SW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned XW = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
  localparam int unsigned LW = $clog2(CMD_WIDTH + 1);
  localparam logic [6:0] DEF_COUNT = 7'((DEF_LEN < CMD_DEPTH) ? DEF_LEN : CMD_DEPTH);

  logic [7:0]    mem [NUM_BANKS][CMD_DEPTH][CMD_WIDTH];
  logic [6:0]    count [NUM_BANKS];
  logic [7:0]    line_buf [CMD_WIDTH];
  logic [BW-1:0] act_bank;
  logic [XW-1:0] cidx;
  logic          fetch_wait;
  logic          byte_stb;
  logic          committing;
  logic          commit_done;
  logic [7:0]    rd_mux;
  int unsigned   lin;

  pstate_e       pstate;
  line_kind_e    kind;
  logic [6:0]    slot;
  logic [3:0]    bank_sel;
  logic [LW-1:0] txt_len;
  logic          txt_we;
  err_code_e     perr;

  assign byte_stb    = fetch_wait && rx.data_valid && enable;
  assign committing  = (pstate == P_COMMIT);
  assign commit_done = committing && ((kind != K_WRITE) || (cidx == XW'(CMD_WIDTH - 1)));
  assign busy        = committing;
  assign error_code  = perr;

  cmd_line_parser #(
    .CMD_WIDTH (CMD_WIDTH),
    .CMD_DEPTH (CMD_DEPTH),
    .NUM_BANKS (NUM_BANKS),
    .LW        (LW)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .byte_stb    (byte_stb),
    .byte_in     (rx.cmd_data),
    .cnt         (count[act_bank]),
    .commit_done (commit_done),
    .state       (pstate),
    .kind        (kind),
    .slot        (slot),
    .bank_sel    (bank_sel),
    .txt_len     (txt_len),
    .txt_we      (txt_we),
    .error_pulse (error_pulse),
    .error_code  (perr)
  );

  // Fetcher: one rd_en pulse per byte, then hold off until data_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rd_en   <= 1'b0;
      fetch_wait <= 1'b0;
    end else begin
      rx.rd_en <= 1'b0;
      if (fetch_wait) begin
        if (rx.data_valid) fetch_wait <= 1'b0;
      end else if (enable && rx.data_ready && !committing) begin
        rx.rd_en   <= 1'b1;
        fetch_wait <= 1'b1;
      end
    end
  end

  // Line buffer stages text so the banks only change during commit
  always_ff @(posedge clk) begin
    if (txt_we) line_buf[XW'(txt_len)] <= rx.cmd_data;
  end

  // Commit engine and bank storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_bank   <= '0;
      cidx       <= '0;
      write_done <= 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
`ifdef CMD_MEM_DEFAULTS_EN
        count[b] <= (b == 0) ? DEF_COUNT : 7'd0;
`else
        count[b] <= '0;
`endif
        for (int unsigned s = 0; s < CMD_DEPTH; s++) begin
          for (int unsigned k = 0; k < CMD_WIDTH; k++) begin
`ifdef CMD_MEM_DEFAULTS_EN
            mem[b][s][k] <= (b == 0) ? def_byte(s, k) : 8'h00;
`else
            mem[b][s][k] <= '0;
`endif
          end
        end
      end
    end else begin
      write_done <= 1'b0;
      if (committing) begin
        case (kind)
          K_WRITE: begin
            mem[act_bank][SW'(slot)][cidx] <= (LW'(cidx) < txt_len) ? line_buf[cidx] : 8'h00;
            if (cidx == XW'(CMD_WIDTH - 1)) begin
              cidx       <= '0;
              write_done <= 1'b1;
              if (slot == count[act_bank]) count[act_bank] <= count[act_bank] + 7'd1;
            end else begin
              cidx <= cidx + 1'b1;
            end
          end
          K_BANK:  act_bank <= BW'(bank_sel);
          default: count[act_bank] <= '0;
        endcase
      end
    end
  end

  // Read mux: addr 0 is the bank count, addr k>0 is flattened byte k-1
  always_comb begin
    rd_mux = 8'h00;
    lin    = 0;
    if (32'(rd_bank) < NUM_BANKS) begin
      if (rd_addr == '0) begin
        rd_mux = {1'b0, count[rd_bank]};
      end else if (32'(rd_addr) <= CMD_DEPTH * CMD_WIDTH) begin
        lin    = 32'(rd_addr) - 32'd1;
        rd_mux = mem[rd_bank][SW'(lin / CMD_WIDTH)][XW'(lin % CMD_WIDTH)];
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_cmd_bank_memory.sv
// Directed bench for cmd_bank_memory: a byte-queue FIFO model feeds
// command lines; results are checked through the read port and pulses.
module tb_cmd_bank_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] rd_bank;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       write_done;
  logic       error_pulse;
  logic [2:0] error_code;

  cmd_bank_memory_if rx();

  cmd_bank_memory #(
    .CMD_WIDTH (32),
    .CMD_DEPTH (16),
    .NUM_BANKS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx          (rx),
    .rd_bank     (rd_bank),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .write_done  (write_done),
    .error_pulse (error_pulse),
    .error_code  (error_code)
  );

  always #5 clk = ~clk;

`ifdef CMD_MEM_DEFAULTS_EN
  localparam logic [7:0] EXP_RST_CNT = 8'd2;
`else
  localparam logic [7:0] EXP_RST_CNT = 8'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  int wd_cnt, err_cnt, busy_cyc, rd_double, rd_seen;
  logic [2:0] last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endtask

  task automatic clear_mon();
    wd_cnt = 0; err_cnt = 0; busy_cyc = 0; last_err = 3'd0;
  endtask

  // FIFO model: answers each rd_en with one data_valid byte half a cycle later
  task automatic pump(input string tag);
    int   idle = 0;
    logic prev_rd = 1'b0;
    for (int c = 0; (c < 4000) && (idle < 3); c++) begin
      @(negedge clk);
      if (write_done) wd_cnt++;
      if (error_pulse) begin err_cnt++; last_err = error_code; end
      if (busy) busy_cyc++;
      if (rx.rd_en && prev_rd) rd_double++;
      prev_rd = rx.rd_en;
      if (rx.rd_en && (q.size() > 0)) begin
        rx.cmd_data   = q.pop_front();
        rx.data_valid = 1'b1;
      end else begin
        rx.data_valid = 1'b0;
      end
      rx.data_ready = (q.size() != 0);
      if ((q.size() == 0) && !busy && !rx.rd_en && !rx.data_valid) idle++;
      else idle = 0;
    end
    check({tag, "_finished"}, 32'(idle >= 3), 32'd1);
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] b, input int a, input logic [7:0] e);
    @(negedge clk);
    rd_bank = b;
    rd_addr = 10'(a);
    @(negedge clk);
    check(tag, {24'h0, rd_data}, {24'h0, e});
  endtask

  initial begin
    string s;
    string lng;
    rst_n = 1'b0; enable = 1'b0; rd_bank = '0; rd_addr = '0;
    rx.data_ready = 1'b0; rx.data_valid = 1'b0; rx.cmd_data = '0;
    rd_double = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rx.rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_done", 32'(write_done), 32'd0);
    check("rst_error_pulse", 32'(error_pulse), 32'd0);
    check("rst_error_code", 32'(error_code), 32'd0);
    rst_n = 1'b1;
    chk_rd("rst_b0_count", 2'd0, 0, EXP_RST_CNT);

    // Two writes to bank 0
    enable = 1'b1;
    clear_mon();
    push_line("00 AT+X", 1'b1);
    push_line("01 AT+Y", 1'b1);
    pump("wr2");
    check("wr2_write_done", wd_cnt, 2);
    check("wr2_errors", err_cnt, 0);
    check("wr2_busy_cycles", busy_cyc, 64);
    chk_rd("wr2_b0_count", 2'd0, 0, 8'd2);
    s = "AT+X";
    for (int i = 0; i < 4; i++) chk_rd($sformatf("wr2_b0_s0_b%0d", i), 2'd0, i + 1, s[i]);
    chk_rd("wr2_b0_s0_tail", 2'd0, 5, 8'h00);
    s = "AT+Y";
    for (int i = 0; i < 4; i++) chk_rd($sformatf("wr2_b0_s1_b%0d", i), 2'd0, 33 + i, s[i]);

    // Error lines with count 2
    clear_mon(); push_line("05 AT", 1'b1); pump("e2");
    check("e2_pulses", err_cnt, 1); check("e2_code", 32'(last_err), 2); check("e2_wd", wd_cnt, 0);
    clear_mon(); push_line("0xAT", 1'b1); pump("e3");
    check("e3_pulses", err_cnt, 1); check("e3_code", 32'(last_err), 3);
    lng = "00 ";
    for (int i = 0; i < 40; i++) lng = {lng, "Q"};
    clear_mon(); push_line(lng, 1'b1); pump("e1");
    check("e1_pulses", err_cnt, 1); check("e1_code", 32'(last_err), 1); check("e1_wd", wd_cnt, 0);
    clear_mon(); push_line("B7", 1'b1); pump("e5");
    check("e5_pulses", err_cnt, 1); check("e5_code", 32'(last_err), 5);
    clear_mon(); push_line("ZZ", 1'b1); pump("e6");
    check("e6_pulses", err_cnt, 1); check("e6_code", 32'(last_err), 6);
    chk_rd("err_b0_count", 2'd0, 0, 8'd2);
    chk_rd("err_b0_s0_b0", 2'd0, 1, 8'h41);
    chk_rd("err_b0_s0_b3", 2'd0, 4, 8'h58);
    chk_rd("err_b0_s1_tail", 2'd0, 37, 8'h00);

    // Bank select and write to bank 1
    clear_mon(); push_line("B1", 1'b1); push_line("00 AT", 1'b1); pump("bank");
    check("bank_wd", wd_cnt, 1); check("bank_errors", err_cnt, 0);
    chk_rd("bank_b1_count", 2'd1, 0, 8'd1);
    chk_rd("bank_b1_b0", 2'd1, 1, 8'h41);
    chk_rd("bank_b1_b1", 2'd1, 2, 8'h54);
    chk_rd("bank_b1_b2", 2'd1, 3, 8'h00);
    chk_rd("bank_b0_count", 2'd0, 0, 8'd2);

    // Fill bank 2, then overflow
    clear_mon(); push_line("B2", 1'b1);
    for (int i = 0; i < 16; i++) push_line($sformatf("%02d Z", i), 1'b1);
    pump("fill");
    check("fill_wd", wd_cnt, 16); check("fill_errors", err_cnt, 0);
    chk_rd("fill_b2_count", 2'd2, 0, 8'd16);
    chk_rd("fill_b2_s15_b0", 2'd2, 15 * 32 + 1, 8'h5A);
    clear_mon(); push_line("16 Z", 1'b1); pump("full");
    check("full_pulses", err_cnt, 1); check("full_code", 32'(last_err), 4);
    chk_rd("full_b2_count", 2'd2, 0, 8'd16);

    // Enable dropped mid-line
    clear_mon(); push_line("03 AT", 1'b0); pump("part");
    enable = 1'b0;
    push_line("00 OK", 1'b1);
    rx.data_ready = 1'b1;
    rd_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx.rd_en) rd_seen++;
    end
    check("dis_rd_en_pulses", rd_seen, 0);
    check("dis_queue_left", q.size(), 7);
    check("dis_wd", wd_cnt, 0); check("dis_errors", err_cnt, 0);
    chk_rd("dis_b2_s3_b0", 2'd2, 97, 8'h5A);
    chk_rd("dis_b2_s3_b1", 2'd2, 98, 8'h00);
    enable = 1'b1;
    pump("ok");
    check("ok_wd", wd_cnt, 1); check("ok_errors", err_cnt, 0); check("ok_busy_cycles", busy_cyc, 32);
    chk_rd("ok_b2_s0_b0", 2'd2, 1, 8'h4F);
    chk_rd("ok_b2_s0_b1", 2'd2, 2, 8'h4B);
    chk_rd("ok_b2_s0_b2", 2'd2, 3, 8'h00);
    chk_rd("ok_b2_count", 2'd2, 0, 8'd16);
    chk_rd("ok_b2_s3_b0", 2'd2, 97, 8'h5A);

    // Clear active bank
    clear_mon(); push_line("CR", 1'b1); pump("clr");
    check("clr_errors", err_cnt, 0); check("clr_wd", wd_cnt, 0); check("clr_busy_cycles", busy_cyc, 1);
    chk_rd("clr_b2_count", 2'd2, 0, 8'd0);
    chk_rd("clr_b0_count", 2'd0, 0, 8'd2);

    check("rd_en_single_cycle", rd_double, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
